eab_pipe: RTL and testbench

- Parametrised, pipelined effective-address generator for the LC-3 datapath family.
- Computes base + sign-extended IR offset for PC-relative, base+offset and chained (indirect) addressing.
- Valid/ready handshakes on both sides, so it can sit between decode and the memory-address register while memory stalls.
- Adds over the combinational address adder: configurable width, offset scaling, 1- or 2-stage pipelining, a result-chaining base, and carry and page-crossing flags.

---
 rtl/eab_pipe.sv | 161 ++++++++++++++++
 tb/tb_eab_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eab_pipe.sv
// eab_pipe -- pipelined effective-address generator for the LC-3 datapath.
//
// Computes ea = base + (sign-extended IR offset << SHIFT). The base is one of
// pc, ra, zero, or the previous result. Valid/ready handshakes are used on both
// sides, and the block has 1 or 2 register stages (PIPE).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (ir, ra, pc, sel_* sampled on accept)
//   ir                    instruction offset bits [IRW-1:0]
//   ra, pc                base register value, incremented PC
//   sel_base              0 = pc, 1 = ra, 2 = zero, 3 = last result
//   sel_off               0 = zero, 1 = IR[5:0], 2 = IR[8:0], 3 = IR[IRW-1:0]
//   out_valid / out_ready result handshake
//   ea_out                effective address (modulo 2^WIDTH)
//   carry_out             unsigned carry out of the add
//   page_cross            upper PAGE_BITS of ea_out differ from the base
module eab_pipe #(
   parameter int WIDTH     = 16,
   parameter int IRW       = 11,
   parameter int PIPE      = 2,
   parameter int SHIFT     = 0,
   parameter int PAGE_BITS = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IRW-1:0]   ir,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] pc,
   input  logic [1:0]       sel_base,
   input  logic [1:0]       sel_off,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ea_out,
   output logic             carry_out,
   output logic             page_cross
);

   // Sign-extends the selected IR field to WIDTH and applies the scale shift.
   function automatic logic [WIDTH-1:0] scaledOffset(input logic [1:0] sel,
                                                     input logic [IRW-1:0] irv);
      logic signed [5:0]       f6;
      logic signed [8:0]       f9;
      logic signed [IRW-1:0]   fN;
      logic signed [WIDTH-1:0] ext;
      f6 = irv[5:0];
      f9 = irv[8:0];
      fN = irv;
      case (sel)
         2'd1:    ext = WIDTH'(f6);
         2'd2:    ext = WIDTH'(f9);
         2'd3:    ext = WIDTH'(fN);
         default: ext = '0;
      endcase
      return ext << SHIFT;
   endfunction

   logic [WIDTH-1:0] baseSel;
   logic [WIDTH-1:0] offSel;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] eaNext;
   logic             carryNext;
   logic             pageNext;
   logic [WIDTH-1:0] lastEa;

   logic             vld_p1;
   logic [WIDTH-1:0] ea_p1;
   logic             carry_p1;
   logic             page_p1;
   logic             rdy_p1;
   logic             nextRdy;
   logic             accept;

   // Stage 0: operand select and add (combinational, ahead of stage 1)
   always_comb begin
      baseSel = pc;
      case (sel_base)
         2'd1:    baseSel = ra;
         2'd2:    baseSel = '0;
         2'd3:    baseSel = lastEa;
         default: baseSel = pc;
      endcase
      offSel    = scaledOffset(sel_off, ir);
      sum       = {1'b0, baseSel} + {1'b0, offSel};
      eaNext    = sum[WIDTH-1:0];
      carryNext = sum[WIDTH];
      pageNext  = eaNext[WIDTH-1 -: PAGE_BITS] != baseSel[WIDTH-1 -: PAGE_BITS];
   end

   assign rdy_p1   = !vld_p1 || nextRdy;
   assign in_ready = rdy_p1;
   assign accept   = in_valid && rdy_p1;

   // Stage 1: capture on acceptance; lastEa feeds chained requests without a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         ea_p1    <= '0;
         carry_p1 <= 1'b0;
         page_p1  <= 1'b0;
         lastEa   <= '0;
      end else begin
         if (rdy_p1) vld_p1 <= accept;
         if (accept) begin
            ea_p1    <= eaNext;
            carry_p1 <= carryNext;
            page_p1  <= pageNext;
            lastEa   <= eaNext;
         end
      end
   end

   if (WIDTH < IRW || IRW < 9 || SHIFT < 0 || SHIFT > 3 ||
       PAGE_BITS < 1 || PAGE_BITS > WIDTH) begin : gBadParam
      $error("eab_pipe: illegal WIDTH/IRW/SHIFT/PAGE_BITS combination");
   end

   if (PIPE == 1) begin : gOne
      assign nextRdy    = out_ready;
      assign out_valid  = vld_p1;
      assign ea_out     = ea_p1;
      assign carry_out  = carry_p1;
      assign page_cross = page_p1;
   end else if (PIPE == 2) begin : gTwo
      logic             vld_p2;
      logic [WIDTH-1:0] ea_p2;
      logic             carry_p2;
      logic             page_p2;
      logic             rdy_p2;

      assign rdy_p2  = !vld_p2 || out_ready;
      assign nextRdy = rdy_p2;

      // Stage 2: refills when empty or when its current result is consumed
      always_ff @(posedge clk) begin
         if (reset) begin
            vld_p2   <= 1'b0;
            ea_p2    <= '0;
            carry_p2 <= 1'b0;
            page_p2  <= 1'b0;
         end else if (rdy_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               ea_p2    <= ea_p1;
               carry_p2 <= carry_p1;
               page_p2  <= page_p1;
            end
         end
      end

      assign out_valid  = vld_p2;
      assign ea_out     = ea_p2;
      assign carry_out  = carry_p2;
      assign page_cross = page_p2;
   end else begin : gBadPipe
      $error("eab_pipe: PIPE must be 1 or 2");
   end

endmodule

// File: tb/tb_eab_pipe.sv
// Bench for eab_pipe: two instances share one input stream.
//   dut0: PIPE=2, SHIFT=0    dut1: PIPE=1, SHIFT=1
// A transaction-level model (occupancy + age per in-flight result) predicts
// handshakes and data each cycle. Directed vectors cover the corner cases.
module tb_eab_pipe;
   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [10:0] ir;
   logic [15:0] ra, pc;
   logic [1:0]  selBase, selOff;

   logic        inRdy0, outVld0, carry0, page0;
   logic [15:0] ea0;
   logic        inRdy1, outVld1, carry1, page1;
   logic [15:0] ea1;

   always #5 clk = ~clk;

   eab_pipe #(.WIDTH(16), .IRW(11), .PIPE(2), .SHIFT(0), .PAGE_BITS(7)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inRdy0),
      .ir(ir), .ra(ra), .pc(pc), .sel_base(selBase), .sel_off(selOff),
      .out_valid(outVld0), .out_ready(out_ready), .ea_out(ea0),
      .carry_out(carry0), .page_cross(page0));

   eab_pipe #(.WIDTH(16), .IRW(11), .PIPE(1), .SHIFT(1), .PAGE_BITS(7)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inRdy1),
      .ir(ir), .ra(ra), .pc(pc), .sel_base(selBase), .sel_off(selOff),
      .out_valid(outVld1), .out_ready(out_ready), .ea_out(ea1),
      .carry_out(carry1), .page_cross(page1));

   int nChk = 0;
   int nErr = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Staged stimulus, applied at the falling edge
   logic        sRst = 1'b1, sIv = 1'b0, sOr = 1'b1;
   logic [10:0] sIr = '0;
   logic [15:0] sRa = '0, sPc = '0;
   logic [1:0]  sSb = '0, sSo = '0;
   bit          chkEn = 0;

   // Model: up to two in-flight results per instance, oldest at index 0
   int          np[2] = '{2, 1};
   int          sh[2] = '{0, 1};
   int          cnt[2] = '{0, 0};
   logic [15:0] qEa[2][2];
   bit          qC[2][2];
   bit          qP[2][2];
   int          qAge[2][2];
   logic [15:0] mLast[2] = '{16'h0, 16'h0};

   bit          record = 0;
   int          nGot = 0;
   logic [15:0] got[8];
   bit          lastAcc0;

   function automatic void refCalc(input int d, output logic [15:0] ea, output bit c, output bit p);
      longint base, off, sum;
      case (selBase)
         2'd0:    base = pc;
         2'd1:    base = ra;
         2'd2:    base = 0;
         default: base = mLast[d];
      endcase
      case (selOff)
         2'd0: off = 0;
         2'd1: begin off = ir[5:0]; if (off >= 32)   off -= 64;   end
         2'd2: begin off = ir[8:0]; if (off >= 256)  off -= 512;  end
         default: begin off = ir;   if (off >= 1024) off -= 2048; end
      endcase
      off = (off * (longint'(1) << sh[d])) & 64'hFFFF;
      sum = base + off;
      ea  = sum[15:0];
      c   = (sum >= 65536);
      p   = ((longint'(ea) >> 9) != (base >> 9));
   endfunction

   task automatic cycle();
      bit          acc[2], pop[2], rC[2], rP[2];
      logic [15:0] rEa[2];
      @(negedge clk);
      reset = sRst; in_valid = sIv; out_ready = sOr;
      ir = sIr; ra = sRa; pc = sPc; selBase = sSb; selOff = sSo;
      #1;
      for (int d = 0; d < 2; d++) begin
         bit mv, mr;
         logic gv, gr, gc, gp;
         logic [15:0] ge;
         gv = (d == 0) ? outVld0 : outVld1;
         gr = (d == 0) ? inRdy0  : inRdy1;
         ge = (d == 0) ? ea0     : ea1;
         gc = (d == 0) ? carry0  : carry1;
         gp = (d == 0) ? page0   : page1;
         mv = (cnt[d] > 0) && (qAge[d][0] >= np[d]);
         mr = (cnt[d] < np[d]) || out_ready;
         if (chkEn) begin
            checkVal($sformatf("out_valid%0d", d), gv, mv);
            checkVal($sformatf("in_ready%0d", d), gr, mr);
            if (mv) begin
               checkVal($sformatf("ea%0d", d), ge, qEa[d][0]);
               checkVal($sformatf("carry%0d", d), gc, qC[d][0]);
               checkVal($sformatf("page%0d", d), gp, qP[d][0]);
            end
         end
         acc[d] = in_valid && mr && !reset;
         pop[d] = mv && out_ready;
         refCalc(d, rEa[d], rC[d], rP[d]);
         if (record && d == 0 && pop[0] && nGot < 8) begin
            got[nGot] = ea0;
            nGot++;
         end
      end
      lastAcc0 = acc[0];
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            cnt[d] = 0;
            mLast[d] = '0;
         end else begin
            if (pop[d]) begin
               qEa[d][0] = qEa[d][1]; qC[d][0] = qC[d][1];
               qP[d][0] = qP[d][1];   qAge[d][0] = qAge[d][1];
               cnt[d]--;
            end
            for (int i = 0; i < cnt[d]; i++) qAge[d][i]++;
            if (acc[d]) begin
               qEa[d][cnt[d]] = rEa[d]; qC[d][cnt[d]] = rC[d];
               qP[d][cnt[d]] = rP[d];   qAge[d][cnt[d]] = 1;
               cnt[d]++;
               mLast[d] = rEa[d];
            end
         end
      end
   endtask

   task automatic req(input logic [1:0] sb, input logic [1:0] so, input logic [10:0] irv,
                      input logic [15:0] rav, input logic [15:0] pcv);
      sIv = 1'b1; sSb = sb; sSo = so; sIr = irv; sRa = rav; sPc = pcv;
      cycle();
      sIv = 1'b0;
   endtask

   task automatic idle();
      sIv = 1'b0;
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      // Reset
      sRst = 1'b1; cycle(); cycle();
      sRst = 1'b0; chkEn = 1;
      idle();
      #1;
      checkVal("rst_out_valid", outVld0, 0);
      checkVal("rst_in_ready", inRdy0, 1);
      checkVal("rst_ea", ea0, 16'h0000);
      checkVal("rst_carry", carry0, 0);
      checkVal("rst_page", page0, 0);

      // PC-relative, negative offset with carry
      sOr = 1'b1;
      req(2'd0, 2'd2, 11'h1FF, 16'h0000, 16'h3001); idle(); #1;
      checkVal("v1_valid", outVld0, 1);
      checkVal("v1_ea", ea0, 16'h3000);
      checkVal("v1_carry", carry0, 1);
      checkVal("v1_page", page0, 0);

      // Base+offset crossing a page
      req(2'd1, 2'd1, 11'h001, 16'h7FFF, 16'h0000); idle(); #1;
      checkVal("v2_ea", ea0, 16'h8000);
      checkVal("v2_carry", carry0, 0);
      checkVal("v2_page", page0, 1);

      // Wrap-around
      req(2'd1, 2'd3, 11'h001, 16'hFFFF, 16'h0000); idle(); #1;
      checkVal("v3_ea", ea0, 16'h0000);
      checkVal("v3_carry", carry0, 1);
      checkVal("v3_page", page0, 1);

      // Scaled offset on the SHIFT=1, single-stage instance
      req(2'd0, 2'd1, 11'h03F, 16'h0000, 16'h1000); #1;
      checkVal("v4_valid1", outVld1, 1);
      checkVal("v4_ea1", ea1, 16'h0FFE);
      idle();

      // Back-to-back chaining
      req(2'd0, 2'd2, 11'h010, 16'h0000, 16'h4000);
      req(2'd3, 2'd0, 11'h000, 16'h0000, 16'h0000); #1;
      checkVal("chainA_valid", outVld0, 1);
      checkVal("chainA_ea", ea0, 16'h4010);
      idle(); #1;
      checkVal("chainB_valid", outVld0, 1);
      checkVal("chainB_ea", ea0, 16'h4010);
      idle(); idle();

      // Backpressure: 4 requests, out_ready low for 5 cycles
      record = 1; nGot = 0; idx = 0;
      for (int c = 0; c < 40 && nGot < 4; c++) begin
         sIv = (idx < 4); sSb = 2'd0; sSo = 2'd0; sIr = '0;
         sPc = 16'h5000 + 16'(idx);
         sOr = (c >= 5);
         cycle();
         if (lastAcc0) idx++;
         if (c == 4) begin
            #1;
            checkVal("bp_in_ready_full", inRdy0, 0);
            checkVal("bp_accepted", idx, 2);
         end
      end
      record = 0;
      sIv = 1'b0;
      checkVal("bp_count", nGot, 4);
      for (int i = 0; i < 4; i++)
         checkVal($sformatf("bp_order%0d", i), (i < nGot) ? got[i] : 16'hXXXX, 16'h5000 + 16'(i));

      // Reset mid-stream discards in-flight results
      sOr = 1'b0;
      req(2'd0, 2'd0, 11'h0, 16'h0, 16'h6000);
      req(2'd0, 2'd0, 11'h0, 16'h0, 16'h6001);
      sRst = 1'b1; idle(); #1;
      checkVal("mid_rst_valid0", outVld0, 0);
      checkVal("mid_rst_valid1", outVld1, 0);
      checkVal("mid_rst_ready0", inRdy0, 1);
      sRst = 1'b0; idle(); #1;
      checkVal("post_rst_ready0", inRdy0, 1);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         sRst = ($urandom_range(0, 99) == 0);
         sIv  = ($urandom_range(0, 9) < 7);
         sOr  = ($urandom_range(0, 9) < 7);
         sIr  = 11'($urandom);
         case ($urandom_range(0, 3))
            0:       sRa = 16'hFFFF;
            1:       sRa = 16'h7FFF;
            default: sRa = 16'($urandom);
         endcase
         sPc = 16'($urandom);
         sSb = 2'($urandom);
         sSo = 2'($urandom);
         cycle();
      end
      sRst = 1'b0; sIv = 1'b0; sOr = 1'b1;
      idle(); idle(); idle();

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end
endmodule
